// File: rtl/autotune_pkg.sv
// Shared definitions for the autotune pitch path: searcher value widths,
// ratio fixed-point format and the ratio divider state type.
package autotune_pkg;

  // Width of the frequency values produced by the semitone searcher
  localparam int FREQ_WIDTH      = 12;

  // Fixed-point format of the pitch-shift ratio, Q(INT).(FRAC)
  localparam int RATIO_FRAC_BITS = 12;
  localparam int RATIO_INT_BITS  = 4;
  localparam int RATIO_BITS      = RATIO_INT_BITS + RATIO_FRAC_BITS;

  // Value reported when the ratio cannot be represented
  localparam logic [RATIO_BITS-1:0] RATIO_MAX = '1;

  // Divider sequencing: waiting for a start, or producing quotient bits
  typedef enum logic {
    IDLE   = 1'b0,
    DIVIDE = 1'b1
  } ratio_state_t;

endpackage

// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider: one quotient bit per clock, MSB first.
// A start loads fresh operands, even in the middle of a division, which
// silently discards the running one. An abort drops back to idle.
// 'done' is asserted combinationally during the cycle whose clock edge
// performs the last step, and 'quotient' already shows the final quotient
// in that cycle, so the parent can register the result on the same edge.
module seq_restoring_divider
  import autotune_pkg::*;
#(
  parameter int NUM_WIDTH = 24,
  parameter int DEN_WIDTH = 12
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 start,
  input  logic                 abort,
  input  logic [NUM_WIDTH-1:0] num,
  input  logic [DEN_WIDTH-1:0] den,
  output logic [NUM_WIDTH-1:0] quotient,
  output logic                 done,
  output logic                 busy
);

  localparam int                ITER_W    = $clog2(NUM_WIDTH + 1);
  localparam logic [ITER_W-1:0] ITER_LOAD = ITER_W'(NUM_WIDTH);
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(1);

  ratio_state_t         state_q, state_d;
  logic [ITER_W-1:0]    iter_q,  iter_d;
  logic [NUM_WIDTH-1:0] num_q,   num_d;
  logic [NUM_WIDTH-1:0] quo_q,   quo_d;
  logic [DEN_WIDTH-1:0] den_q,   den_d;

  // The remainder is always below den, so DEN_WIDTH+1 bits hold the shifted
  // value without overflowing the compare.
  logic [DEN_WIDTH:0]   rem_q,   rem_d;
  logic [DEN_WIDTH:0]   rem_shift;
  logic [DEN_WIDTH:0]   den_ext;
  logic                 step_ge;
  logic [NUM_WIDTH-1:0] quo_step;

  // One restoring step: bring down the next numerator bit and try to subtract
  always_comb begin
    den_ext   = {1'b0, den_q};
    rem_shift = {rem_q[DEN_WIDTH-1:0], num_q[NUM_WIDTH-1]};
    step_ge   = (rem_shift >= den_ext);
    quo_step  = {quo_q[NUM_WIDTH-2:0], step_ge};
  end

  // Next-state and datapath update; a start always wins over an abort
  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    num_d   = num_q;
    quo_d   = quo_q;
    den_d   = den_q;
    rem_d   = rem_q;
    done    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          num_d   = num;
          den_d   = den;
          rem_d   = '0;
          quo_d   = '0;
          iter_d  = ITER_LOAD;
          state_d = DIVIDE;
        end
      end

      DIVIDE: begin
        if (start) begin
          num_d   = num;
          den_d   = den;
          rem_d   = '0;
          quo_d   = '0;
          iter_d  = ITER_LOAD;
          state_d = DIVIDE;
        end else if (abort) begin
          state_d = IDLE;
        end else begin
          rem_d  = step_ge ? (rem_shift - den_ext) : rem_shift;
          num_d  = {num_q[NUM_WIDTH-2:0], 1'b0};
          quo_d  = quo_step;
          iter_d = iter_q - ITER_LAST;
          if (iter_q == ITER_LAST) begin
            done    = 1'b1;
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      iter_q  <= '0;
      num_q   <= '0;
      quo_q   <= '0;
      den_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      num_q   <= num_d;
      quo_q   <= quo_d;
      den_q   <= den_d;
      rem_q   <= rem_d;
    end
  end

  // Expose the quotient including the bit decided this cycle
  always_comb begin
    quotient = quo_step;
    busy     = (state_q == DIVIDE);
  end

endmodule

// File: rtl/pitch_ratio_calc.sv
// Pitch-shift ratio target/detected as unsigned Q(INT_BITS).(FRAC_BITS).
// Wraps the sequential divider with rising-edge start detection on the
// searcher strobe, the zero-detected-frequency path and saturation to the
// ratio range. Results appear at a fixed latency whatever the operands.
module pitch_ratio_calc
  import autotune_pkg::*;
#(
  parameter  int WIDTH       = FREQ_WIDTH,
  parameter  int FRAC_BITS   = RATIO_FRAC_BITS,
  parameter  int INT_BITS    = RATIO_INT_BITS,
  localparam int RATIO_WIDTH = INT_BITS + FRAC_BITS
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   target_valid,
  input  logic [WIDTH-1:0]       target_freq,
  input  logic [WIDTH-1:0]       detected_freq,
  output logic [RATIO_WIDTH-1:0] ratio,
  output logic                   ratio_valid,
  output logic                   ratio_saturated,
  output logic                   busy
);

  localparam int                     NUM_WIDTH = WIDTH + FRAC_BITS;
  localparam logic [RATIO_WIDTH-1:0] SAT_VALUE = '1;

  logic                 valid_prev;
  logic                 start;
  logic [NUM_WIDTH-1:0] num_ext;
  logic                 den_zero_q;
  logic [NUM_WIDTH-1:0] div_quotient;
  logic                 div_done;
  logic                 div_busy;
  logic                 div_abort;
  logic                 overflow;

  // Start on the rising edge of the strobe; numerator gets the fraction bits
  // appended so the integer quotient is already the fixed-point ratio.
  always_comb begin
    start     = target_valid && !valid_prev;
    num_ext   = NUM_WIDTH'(target_freq) << FRAC_BITS;
    div_abort = start && div_busy;
    overflow  = |(div_quotient >> RATIO_WIDTH);
  end

  seq_restoring_divider #(
    .NUM_WIDTH (NUM_WIDTH),
    .DEN_WIDTH (WIDTH)
  ) u_divider (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .start    (start),
    .abort    (div_abort),
    .num      (num_ext),
    .den      (detected_freq),
    .quotient (div_quotient),
    .done     (div_done),
    .busy     (div_busy)
  );

  // Edge-detect history, zero-divisor flag and the registered result; a zero
  // divisor still lets the divider run so the result keeps its fixed latency.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_prev      <= 1'b0;
      den_zero_q      <= 1'b0;
      ratio           <= '0;
      ratio_valid     <= 1'b0;
      ratio_saturated <= 1'b0;
    end else begin
      valid_prev  <= target_valid;
      ratio_valid <= div_done;
      if (start) begin
        den_zero_q <= (detected_freq == '0);
      end
      if (div_done) begin
        if (den_zero_q || overflow) begin
          ratio           <= SAT_VALUE;
          ratio_saturated <= 1'b1;
        end else begin
          ratio           <= div_quotient[RATIO_WIDTH-1:0];
          ratio_saturated <= 1'b0;
        end
      end
    end
  end

  // Busy simply mirrors the divider activity
  always_comb begin
    busy = div_busy;
  end

endmodule

// File: tb/tb_pitch_ratio_calc.sv
// Self-checking bench for pitch_ratio_calc: directed cases plus randomized
// operands compared against a plain-arithmetic reference of the ratio.
module tb_pitch_ratio_calc;
  import autotune_pkg::*;

  localparam int LAT = FREQ_WIDTH + RATIO_FRAC_BITS + 1;

  logic                  clk_in = 1'b0;
  logic                  rst_in;
  logic                  target_valid;
  logic [FREQ_WIDTH-1:0] target_freq;
  logic [FREQ_WIDTH-1:0] detected_freq;
  logic [RATIO_BITS-1:0] ratio;
  logic                  ratio_valid;
  logic                  ratio_saturated;
  logic                  busy;

  int check_count = 0;
  int pass_count  = 0;

  always #5 clk_in = ~clk_in;

  pitch_ratio_calc dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .target_valid    (target_valid),
    .target_freq     (target_freq),
    .detected_freq   (detected_freq),
    .ratio           (ratio),
    .ratio_valid     (ratio_valid),
    .ratio_saturated (ratio_saturated),
    .busy            (busy)
  );

  task automatic checkOutput(input string tag, input longint actual, input longint expected);
    check_count++;
    if (actual == expected) pass_count++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Reference: ratio = floor(target * 2^FRAC / detected), clamped to the format
  function automatic void refRatio(input int t, input int d, output longint r, output longint s);
    longint q;
    if (d == 0) begin
      r = longint'(RATIO_MAX);
      s = 1;
    end else begin
      q = (longint'(t) * (longint'(1) << RATIO_FRAC_BITS)) / longint'(d);
      if (q > longint'(RATIO_MAX)) begin
        r = longint'(RATIO_MAX);
        s = 1;
      end else begin
        r = q;
        s = 0;
      end
    end
  endfunction

  // Raise the strobe for 'hold' cycles and watch one full result window
  task automatic applyStimulus(input int t, input int d, input int hold, input string tag);
    int     pulses = 0;
    int     first  = -1;
    longint er, es;
    refRatio(t, d, er, es);
    target_freq   = FREQ_WIDTH'(t);
    detected_freq = FREQ_WIDTH'(d);
    target_valid  = 1'b1;
    for (int k = 1; k <= LAT + 5; k++) begin
      tick();
      if (k == hold) target_valid = 1'b0;
      if (k == 1)       checkOutput({tag, " busy_first"}, busy, 1);
      if (k == LAT - 1) checkOutput({tag, " busy_last"}, busy, 1);
      if (k == LAT)     checkOutput({tag, " busy_clear"}, busy, 0);
      if (ratio_valid) begin
        pulses++;
        if (first < 0) first = k;
      end
    end
    checkOutput({tag, " pulses"}, pulses, 1);
    checkOutput({tag, " latency"}, first, LAT);
    checkOutput({tag, " ratio"}, ratio, er);
    checkOutput({tag, " saturated"}, ratio_saturated, es);
  endtask

  // Second start arrives 'at' cycles into a 440/400 division
  task automatic restartCase(input int at, input string tag);
    int     pulses = 0;
    int     first  = -1;
    longint er, es;
    refRatio(880, 440, er, es);
    target_freq   = 12'd440;
    detected_freq = 12'd400;
    target_valid  = 1'b1;
    for (int k = 1; k <= at + LAT + 5; k++) begin
      tick();
      if (k == 1) target_valid = 1'b0;
      if (k == at) begin
        target_freq   = 12'd880;
        detected_freq = 12'd440;
        target_valid  = 1'b1;
      end
      if (k == at + 1) target_valid = 1'b0;
      if (ratio_valid) begin
        pulses++;
        if (first < 0) first = k;
      end
    end
    checkOutput({tag, " pulses"}, pulses, 1);
    checkOutput({tag, " latency"}, first, at + LAT);
    checkOutput({tag, " ratio"}, ratio, er);
    checkOutput({tag, " saturated"}, ratio_saturated, es);
  endtask

  // Reset 12 cycles into a division: everything clears, no result follows
  task automatic resetCase();
    int pulses = 0;
    target_freq   = 12'd440;
    detected_freq = 12'd400;
    target_valid  = 1'b1;
    for (int k = 1; k <= LAT + 5; k++) begin
      tick();
      if (k == 1) target_valid = 1'b0;
      if (k == 12) rst_in = 1'b1;
      if (k == 13) begin
        rst_in = 1'b0;
        checkOutput("midreset ratio", ratio, 0);
        checkOutput("midreset saturated", ratio_saturated, 0);
        checkOutput("midreset valid", ratio_valid, 0);
        checkOutput("midreset busy", busy, 0);
      end
      if (ratio_valid) pulses++;
    end
    checkOutput("midreset pulses", pulses, 0);
  endtask

  initial begin
    int t, d, h;
    rst_in        = 1'b1;
    target_valid  = 1'b0;
    target_freq   = '0;
    detected_freq = '0;
    repeat (3) tick();
    checkOutput("reset ratio", ratio, 0);
    checkOutput("reset valid", ratio_valid, 0);
    checkOutput("reset saturated", ratio_saturated, 0);
    checkOutput("reset busy", busy, 0);
    rst_in = 1'b0;
    tick();

    applyStimulus(440, 400, 1, "440/400");
    applyStimulus(1000, 1000, 1, "unity");
    applyStimulus(0, 500, 1, "zero_target");
    applyStimulus(4000, 100, 1, "overflow");
    applyStimulus(440, 0, 1, "zero_detected");
    applyStimulus(440, 400, 2, "held_level");
    applyStimulus(4095, 256, 1, "just_below_max");
    restartCase(10, "restart_mid");
    restartCase(LAT - 1, "restart_last");
    resetCase();
    applyStimulus(440, 400, 1, "after_reset");

    for (int i = 0; i < 16; i++) begin
      t = int'($urandom_range(0, 4095));
      d = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 4095));
      h = int'($urandom_range(1, 3));
      applyStimulus(t, d, h, $sformatf("rand%0d %0d/%0d", i, t, d));
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
